// File: rtl/register_file.sv
// Multi-ported register file: one write port and two read ports with 1-cycle latency.
// Register 0 is hard-wired to zero, and a read sees a write made on the same edge.
module register_file #(
   parameter int unsigned WORDSIZE = 64,
   parameter int unsigned ADDRSIZE = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                write_enable,
   input  logic [ADDRSIZE-1:0] write_addr,
   input  logic [WORDSIZE-1:0] write_data,
   input  logic                read_en_a,
   input  logic [ADDRSIZE-1:0] read_addr_a,
   output logic [WORDSIZE-1:0] read_data_a,
   output logic                read_valid_a,
   input  logic                read_en_b,
   input  logic [ADDRSIZE-1:0] read_addr_b,
   output logic [WORDSIZE-1:0] read_data_b,
   output logic                read_valid_b
);

   localparam int unsigned NREG = 1 << ADDRSIZE;

   logic [WORDSIZE-1:0] mem_q [NREG];
   logic [WORDSIZE-1:0] mem_d [NREG];
   logic [WORDSIZE-1:0] rd_data_a_q, rd_data_a_d;
   logic [WORDSIZE-1:0] rd_data_b_q, rd_data_b_d;
   logic                rd_valid_a_q, rd_valid_a_d;
   logic                rd_valid_b_q, rd_valid_b_d;
   logic                wr_hit_c;

   assign wr_hit_c = write_enable && (write_addr != '0);

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_comb begin
      mem_d = mem_q;
      if (wr_hit_c) begin
         mem_d[write_addr] = write_data;
      end
   end

   // Read word selection with write-first bypass for a same-edge write.
   always_comb begin
      rd_data_a_d  = rd_data_a_q;
      rd_valid_a_d = 1'b0;
      if (read_en_a) begin
         rd_valid_a_d = 1'b1;
         if (read_addr_a == '0) begin
            rd_data_a_d = '0;
         end else if (wr_hit_c && (write_addr == read_addr_a)) begin
            rd_data_a_d = write_data;
         end else begin
            rd_data_a_d = mem_q[read_addr_a];
         end
      end
   end

   always_comb begin
      rd_data_b_d  = rd_data_b_q;
      rd_valid_b_d = 1'b0;
      if (read_en_b) begin
         rd_valid_b_d = 1'b1;
         if (read_addr_b == '0) begin
            rd_data_b_d = '0;
         end else if (wr_hit_c && (write_addr == read_addr_b)) begin
            rd_data_b_d = write_data;
         end else begin
            rd_data_b_d = mem_q[read_addr_b];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q        <= '{default: '0};
         rd_data_a_q  <= '0;
         rd_data_b_q  <= '0;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         rd_data_a_q  <= rd_data_a_d;
         rd_data_b_q  <= rd_data_b_d;
         rd_valid_a_q <= rd_valid_a_d;
         rd_valid_b_q <= rd_valid_b_d;
      end
   end

   assign read_data_a  = rd_data_a_q;
   assign read_valid_a = rd_valid_a_q;
   assign read_data_b  = rd_data_b_q;
   assign read_valid_b = rd_valid_b_q;

endmodule
